// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter.
// The MEM_ARB_RR_EN build switch is consumed by mem_arb_pick.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } arb_port_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between fetch path, load/store path, arbiter and the memory port.
// The slave modport is the arbiter's view; master is the core + memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  i_read;
  logic [ADDR_W-1:0]     i_address;
  logic [DATA_W-1:0]     i_rdata;
  logic                  i_resp;

  logic                  d_read;
  logic                  d_write;
  logic [DATA_W/8-1:0]   d_mbe;
  logic [ADDR_W-1:0]     d_address;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_resp;

  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_W/8-1:0]   mem_byte_enable;
  logic [ADDR_W-1:0]     mem_address;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_resp;

  modport slave (
    input  i_read, i_address,
    output i_rdata, i_resp,
    input  d_read, d_write, d_mbe, d_address, d_wdata,
    output d_rdata, d_resp,
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport master (
    output i_read, i_address,
    input  i_rdata, i_resp,
    output d_read, d_write, d_mbe, d_address, d_wdata,
    input  d_rdata, d_resp,
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and load/store requests.
// MEM_ARB_RR_EN: ties alternate against last_grant; otherwise ties go to D.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic      i_req,
  input  logic      d_req,
  input  arb_port_t last_grant,
  output logic      grant_valid,
  output arb_port_t grant
);

`ifndef MEM_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = (last_grant == PORT_I);
`endif

  always_comb begin
    grant_valid = i_req | d_req;
    grant       = PORT_D;
    if (i_req && !d_req) begin
      grant = PORT_I;
    end else if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      grant = (last_grant == PORT_I) ? PORT_D : PORT_I;
`else
      grant = PORT_D;
`endif
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one
// transaction at a time. Tie policy selected by MEM_ARB_RR_EN (see mem_arb_pick).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t state, state_nxt;
  arb_port_t  last_grant, last_grant_nxt;
  logic       grant_valid;
  arb_port_t  grant;

  logic              mem_read_c;
  logic              mem_write_c;
  logic [BE_W-1:0]   mbe_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;
  logic              i_resp_c;
  logic              d_resp_c;

  mem_arb_pick u_pick (
    .i_req       (bus.i_read),
    .d_req       (bus.d_read | bus.d_write),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= PORT_I;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    mem_read_c     = 1'b0;
    mem_write_c    = 1'b0;
    mbe_c          = '0;
    addr_c         = '0;
    wdata_c        = '0;
    i_resp_c       = 1'b0;
    d_resp_c       = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_nxt = (grant == PORT_I) ? SERVE_I : SERVE_D;
        end
      end
      SERVE_I: begin
        mem_read_c = 1'b1;
        addr_c     = bus.i_address;
        mbe_c      = '1;
        if (bus.mem_resp) begin
          i_resp_c       = 1'b1;
          last_grant_nxt = PORT_I;
          state_nxt      = IDLE;
        end
      end
      SERVE_D: begin
        // A simultaneous read+write request is forwarded as a write only.
        mem_write_c = bus.d_write;
        mem_read_c  = bus.d_read & ~bus.d_write;
        addr_c      = bus.d_address;
        wdata_c     = bus.d_wdata;
        mbe_c       = bus.d_mbe;
        if (bus.mem_resp) begin
          d_resp_c       = 1'b1;
          last_grant_nxt = PORT_D;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.mem_read        = mem_read_c;
  assign bus.mem_write       = mem_write_c;
  assign bus.mem_byte_enable = mbe_c;
  assign bus.mem_address     = addr_c;
  assign bus.mem_wdata       = wdata_c;
  assign bus.i_resp          = i_resp_c;
  assign bus.d_resp          = d_resp_c;
  assign bus.i_rdata         = bus.mem_rdata;
  assign bus.d_rdata         = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter plus a random phase guarding read/write exclusivity.
// Tie expectations follow MEM_ARB_RR_EN.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic        exp_first_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_read    = 1'b0;
    bus.i_address = '0;
    bus.d_read    = 1'b0;
    bus.d_write   = 1'b0;
    bus.d_mbe     = '0;
    bus.d_address = '0;
    bus.d_wdata   = '0;
    bus.mem_resp  = 1'b0;
  endtask

  always @(negedge clk) begin
    check("rw_excl", {63'd0, bus.mem_read & bus.mem_write}, 64'd0);
    check("resp_excl", {63'd0, bus.i_resp & bus.d_resp}, 64'd0);
  end

  initial begin
`ifdef MEM_ARB_RR_EN
    exp_first_i = 1'b1;
`else
    exp_first_i = 1'b0;
`endif
    rst = 1'b1;
    clear_inputs();
    bus.mem_rdata = '0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("rst_mem_read", bus.mem_read, 0);
    check("rst_mem_write", bus.mem_write, 0);
    check("rst_mbe", bus.mem_byte_enable, 0);
    check("rst_addr", bus.mem_address, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_i_resp", bus.i_resp, 0);
    check("rst_d_resp", bus.d_resp, 0);

    // First tie after reset: D wins in both builds, then I after one idle cycle
    bus.i_read = 1'b1; bus.i_address = 32'h200;
    bus.d_read = 1'b1; bus.d_address = 32'h300; bus.d_mbe = 4'hF;
    #1 check("tie1_idle_no_strobe", bus.mem_read, 0);
    tick();
    check("tie1_first_read", bus.mem_read, 1);
    check("tie1_first_addr", bus.mem_address, 32'h300);
    bus.mem_resp = 1'b1; bus.mem_rdata = 32'h0000A5A5;
    #1;
    check("tie1_d_resp", bus.d_resp, 1);
    check("tie1_d_rdata", bus.d_rdata, 32'h0000A5A5);
    check("tie1_i_resp_low", bus.i_resp, 0);
    tick();
    bus.mem_resp = 1'b0; bus.d_read = 1'b0;
    #1;
    check("tie1_gap_read", bus.mem_read, 0);
    check("tie1_gap_addr", bus.mem_address, 0);
    tick();
    check("tie1_second_read", bus.mem_read, 1);
    check("tie1_second_addr", bus.mem_address, 32'h200);
    check("tie1_second_mbe", bus.mem_byte_enable, 4'hF);
    bus.mem_resp = 1'b1; bus.mem_rdata = 32'h00000011;
    #1;
    check("tie1_i_resp", bus.i_resp, 1);
    check("tie1_d_resp_low", bus.d_resp, 0);
    tick();
    bus.mem_resp = 1'b0; bus.i_read = 1'b0;

    // Lone fetch
    bus.i_address = 32'h60; bus.i_read = 1'b1;
    #1 check("fetch_idle_read", bus.mem_read, 0);
    tick();
    check("fetch_read", bus.mem_read, 1);
    check("fetch_addr", bus.mem_address, 32'h60);
    check("fetch_mbe", bus.mem_byte_enable, 4'hF);
    check("fetch_write", bus.mem_write, 0);
    tick();
    tick();
    check("fetch_wait_resp", bus.i_resp, 0);
    tick();
    bus.mem_resp = 1'b1; bus.mem_rdata = 32'h00000013;
    #1;
    check("fetch_i_resp", bus.i_resp, 1);
    check("fetch_i_rdata", bus.i_rdata, 32'h00000013);
    tick();
    bus.mem_resp = 1'b0; bus.i_read = 1'b0;
    #1 check("fetch_done_read", bus.mem_read, 0);

    // Lone store
    bus.d_write = 1'b1; bus.d_address = 32'h100; bus.d_wdata = 32'hDEADBEEF; bus.d_mbe = 4'h3;
    tick();
    check("store_write", bus.mem_write, 1);
    check("store_read", bus.mem_read, 0);
    check("store_mbe", bus.mem_byte_enable, 4'h3);
    check("store_wdata", bus.mem_wdata, 32'hDEADBEEF);
    check("store_addr", bus.mem_address, 32'h100);
    tick();
    bus.mem_resp = 1'b1;
    #1;
    check("store_d_resp", bus.d_resp, 1);
    check("store_i_resp_low", bus.i_resp, 0);
    tick();
    bus.mem_resp = 1'b0; bus.d_write = 1'b0;
    #1 check("store_done_write", bus.mem_write, 0);

    // Repeat tie with last grant = D
    bus.i_read = 1'b1; bus.i_address = 32'h200;
    bus.d_read = 1'b1; bus.d_address = 32'h300; bus.d_mbe = 4'hF;
    tick();
    check("tie2_first_addr", bus.mem_address, exp_first_i ? 32'h200 : 32'h300);
    bus.mem_resp = 1'b1;
    #1;
    check("tie2_first_i_resp", bus.i_resp, exp_first_i);
    check("tie2_first_d_resp", bus.d_resp, !exp_first_i);
    tick();
    bus.mem_resp = 1'b0;
    if (exp_first_i) bus.i_read = 1'b0;
    else bus.d_read = 1'b0;
    #1 check("tie2_gap_read", bus.mem_read, 0);
    tick();
    check("tie2_second_addr", bus.mem_address, exp_first_i ? 32'h300 : 32'h200);
    bus.mem_resp = 1'b1;
    #1 check("tie2_second_i_resp", bus.i_resp, !exp_first_i);
    tick();
    clear_inputs();

    // Illegal simultaneous read+write from the data port
    bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_address = 32'h40;
    bus.d_wdata = 32'h12345678; bus.d_mbe = 4'hC;
    tick();
    check("illegal_write", bus.mem_write, 1);
    check("illegal_read", bus.mem_read, 0);
    check("illegal_mbe", bus.mem_byte_enable, 4'hC);
    bus.mem_resp = 1'b1;
    #1 check("illegal_d_resp", bus.d_resp, 1);
    tick();
    clear_inputs();

    // Reset two cycles into a store, then a stray memory response
    bus.d_write = 1'b1; bus.d_address = 32'h80; bus.d_wdata = 32'hCAFEF00D; bus.d_mbe = 4'hF;
    tick();
    check("rstmid_write_c1", bus.mem_write, 1);
    tick();
    check("rstmid_write_c2", bus.mem_write, 1);
    rst = 1'b1;
    #1 check("rstmid_d_resp_during", bus.d_resp, 0);
    tick();
    rst = 1'b0; bus.d_write = 1'b0;
    #1;
    check("rstmid_write_after", bus.mem_write, 0);
    check("rstmid_read_after", bus.mem_read, 0);
    check("rstmid_d_resp_after", bus.d_resp, 0);
    bus.mem_resp = 1'b1;
    #1;
    check("stray_d_resp", bus.d_resp, 0);
    check("stray_i_resp", bus.i_resp, 0);
    tick();
    bus.mem_resp = 1'b0;
    #1;
    check("stray_write", bus.mem_write, 0);
    check("stray_read", bus.mem_read, 0);

    // Random traffic; exclusivity is checked every cycle on the falling edge
    for (int i = 0; i < 10000; i++) begin
      bus.i_read    = 1'($urandom_range(0, 1));
      bus.d_read    = 1'($urandom_range(0, 1));
      bus.d_write   = 1'($urandom_range(0, 1));
      bus.d_mbe     = 4'($urandom_range(0, 15));
      bus.i_address = $urandom;
      bus.d_address = $urandom;
      bus.d_wdata   = $urandom;
      bus.mem_rdata = $urandom;
      bus.mem_resp  = ($urandom_range(0, 3) == 0);
      tick();
    end
    clear_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
